// File: rtl/dec38_strobe.sv
// dec38_strobe: sequential 3-to-8 strobe decoder.
// Codes arrive over a valid/ready handshake into a small FIFO. Each code then
// drives its one-hot line of x for HOLD cycles, followed by GAP blank cycles.
// Optional feature macro: DEC38_STROBE_SEG_EN adds a registered active-low
// 7-segment view (h) of the code currently driven; without it h is 7'h7F.
//
// Handshake: a code is written on a rising edge where in_valid and in_ready
// are both high. in_ready depends only on the registered occupancy, never on
// in_valid or on a pop in the same cycle, so a full FIFO refuses the push even
// when a pop happens on that edge.
module dec38_strobe #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3,
  parameter int GAP   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_code,
  input  logic                         en,
  output logic [7:0]                   x,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [6:0]                   h,
  output logic [1:0]                   state
);

  localparam int LW      = $clog2(DEPTH + 1);
  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = (GAP > 0) ? CW'(GAP - 1) : '0;
  localparam bit HAS_GAP = (GAP > 0);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  state_t          fsm;
  state_t          fsm_nxt;
  logic [CW-1:0]   cnt;
  logic [7:0]      x_reg;
  logic [2:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level_nxt;
  logic [2:0]      head;
  logic            push;
  logic            pop;
  logic            empty;

  assign in_ready = (level != LW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign empty    = (level == '0);
  assign head     = mem[rd_ptr];
  assign x        = x_reg & {8{en}};
  assign state    = fsm;

  // Next state and pop request; everything holds while en is low.
  always_comb begin
    pop     = 1'b0;
    fsm_nxt = fsm;
    if (en) begin
      case (fsm)
        S_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            fsm_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            if (HAS_GAP)     fsm_nxt = S_GAP;
            else if (!empty) pop     = 1'b1;
            else             fsm_nxt = S_IDLE;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            if (!empty) begin
              pop     = 1'b1;
              fsm_nxt = S_HOLD;
            end else begin
              fsm_nxt = S_IDLE;
            end
          end
        end
        default: fsm_nxt = S_IDLE;
      endcase
    end
  end

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + LW'(1);
    else if (pop && !push) level_nxt = level - LW'(1);
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  // FIFO pointers wrap naturally at DEPTH (a power of two); level kept apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
    end
  end

  // Strobe sequencer: state, hold/gap counter, latched one-hot and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm   <= S_IDLE;
      cnt   <= '0;
      x_reg <= '0;
      busy  <= 1'b0;
    end else begin
      fsm  <= fsm_nxt;
      busy <= (fsm_nxt != S_IDLE) || (level_nxt != '0);
      if (pop) begin
        x_reg <= 8'd1 << head;
        cnt   <= HOLD_LD;
      end else if (en) begin
        case (fsm)
          S_HOLD: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else begin
              // End of hold with nothing to chain into: blank the line.
              x_reg <= '0;
              cnt   <= GAP_LD;
            end
          end
          S_GAP: begin
            if (cnt != '0) cnt <= cnt - CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DEC38_STROBE_SEG_EN
  logic [6:0] seg_reg;

  function automatic logic [6:0] seg_lut(input logic [2:0] c);
    case (c)
      3'd0:    seg_lut = 7'b1000000;
      3'd1:    seg_lut = 7'b1111001;
      3'd2:    seg_lut = 7'b0100100;
      3'd3:    seg_lut = 7'b0110000;
      3'd4:    seg_lut = 7'b0011001;
      3'd5:    seg_lut = 7'b0010010;
      3'd6:    seg_lut = 7'b0000010;
      default: seg_lut = 7'b1111000;
    endcase
  endfunction

  // Segment pattern latched on the same edge as the one-hot line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      seg_reg <= 7'h7F;
    else if (pop) seg_reg <= seg_lut(head);
  end

  // Display is blank whenever the line drive is blank (gap, idle, paused).
  assign h = (x == 8'h00) ? 7'h7F : seg_reg;
`else
  assign h = 7'h7F;
`endif

endmodule
